// File: rtl/mem_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ram_pkg
//  Purpose  : Shared definitions for the dual-port RAM with power-up clear.
//             Holds the clear-FSM state type and the default parameter
//             values used by mem_ram_dp and mem_ram_limpeza.
//  Contents : estado_t (LIMPANDO, PRONTO), *_PADRAO default constants
//  Revision : 1.0 - initial release
// ============================================================================
package mem_ram_pkg;

    // LIMPANDO: clear sweep in progress, both ports ignored.
    // PRONTO  : normal operation.
    typedef enum logic [0:0] {
        LIMPANDO = 1'b0,
        PRONTO   = 1'b1
    } estado_t;

    localparam int LARGURA_PADRAO        = 8;
    localparam int PROFUNDIDADE_PADRAO   = 32;
    localparam int END_LARG_PADRAO       = 7;
    localparam int LIMPA_NO_RESET_PADRAO = 1;

endpackage : mem_ram_pkg
`default_nettype wire

// File: rtl/mem_ram_limpeza.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ram_limpeza
//  Purpose  : Clear-sweep controller. After reset it walks addresses
//             0..PROFUNDIDADE-1 (one per cycle), requesting a zero write to
//             each, then hands the array over to the user ports.
//  Ports    : clk          - clock
//             rst_n        - asynchronous active-low reset
//             ocupado_o    - high while the sweep runs
//             limpa_we_o   - zero-write request for limpa_end_o this cycle
//             limpa_end_o  - address being cleared this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ram_limpeza
    import mem_ram_pkg::*;
#(
    parameter int PROFUNDIDADE   = PROFUNDIDADE_PADRAO,
    parameter int END_LARG       = END_LARG_PADRAO,
    parameter int LIMPA_NO_RESET = LIMPA_NO_RESET_PADRAO
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ocupado_o,
    output logic                limpa_we_o,
    output logic [END_LARG-1:0] limpa_end_o
);

    localparam estado_t             ESTADO_RESET = (LIMPA_NO_RESET != 0) ? LIMPANDO : PRONTO;
    localparam logic [END_LARG-1:0] ULTIMO       = END_LARG'(PROFUNDIDADE - 1);

    estado_t             estado_q, estado_d;
    logic [END_LARG-1:0] cont_q,   cont_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ESTADO_RESET;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
        end
    end

    // Next-state logic: the last word is cleared on the same cycle the FSM
    // leaves LIMPANDO, so the sweep lasts exactly PROFUNDIDADE cycles.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        case (estado_q)
            LIMPANDO: begin
                if (cont_q == ULTIMO) begin
                    estado_d = PRONTO;
                    cont_d   = '0;
                end else begin
                    cont_d   = cont_q + 1'b1;
                end
            end
            PRONTO:  ;
            default: estado_d = ESTADO_RESET;
        endcase
    end

    // Outputs
    always_comb begin
        ocupado_o   = (estado_q == LIMPANDO);
        limpa_we_o  = (estado_q == LIMPANDO);
        limpa_end_o = cont_q;
    end

endmodule : mem_ram_limpeza
`default_nettype wire

// File: rtl/mem_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ram_dp
//  Purpose  : Simple dual-port RAM (one write port, one registered read
//             port, single clock) with optional clear sweep after reset and
//             out-of-range address detection.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             entrada/end_entrada/escrita - write data / address / enable
//             end_saida/leitura     - read address / request
//             saida                 - registered read data (1-cycle latency)
//             saida_valida          - pulse: saida updated this cycle
//             ocupado               - clear sweep running, ports ignored
//             erro_end              - pulse: out-of-range accepted access
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ram_dp
    import mem_ram_pkg::*;
#(
    parameter int LARGURA        = LARGURA_PADRAO,
    parameter int PROFUNDIDADE   = PROFUNDIDADE_PADRAO,
    parameter int END_LARG       = END_LARG_PADRAO,
    parameter int LIMPA_NO_RESET = LIMPA_NO_RESET_PADRAO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LARGURA-1:0]  entrada,
    input  logic [END_LARG-1:0] end_entrada,
    input  logic                escrita,
    input  logic [END_LARG-1:0] end_saida,
    input  logic                leitura,
    output logic [LARGURA-1:0]  saida,
    output logic                saida_valida,
    output logic                ocupado,
    output logic                erro_end
);

    localparam int                IDX_W  = $clog2(PROFUNDIDADE);
    // One extra bit so the bound still fits when PROFUNDIDADE == 2**END_LARG.
    localparam logic [END_LARG:0] LIMITE = (END_LARG + 1)'(PROFUNDIDADE);

    logic [LARGURA-1:0]  mem_q [PROFUNDIDADE];

    logic                limpa_we;
    logic [END_LARG-1:0] limpa_end;

    logic                wr_no_limite, rd_no_limite;
    logic                wr_aceita, wr_efetiva, rd_aceita;
    logic [IDX_W-1:0]    wr_idx, rd_idx, limpa_idx;
    logic [LARGURA-1:0]  saida_d;

    logic [LARGURA-1:0]  saida_q;
    logic                valida_q;
    logic                erro_q;

    mem_ram_limpeza #(
        .PROFUNDIDADE   (PROFUNDIDADE),
        .END_LARG       (END_LARG),
        .LIMPA_NO_RESET (LIMPA_NO_RESET)
    ) u_limpeza (
        .clk         (clk),
        .rst_n       (rst_n),
        .ocupado_o   (ocupado),
        .limpa_we_o  (limpa_we),
        .limpa_end_o (limpa_end)
    );

    always_comb begin
        wr_no_limite = ({1'b0, end_entrada} < LIMITE);
        rd_no_limite = ({1'b0, end_saida}   < LIMITE);
        // rst_n gates the write port: the array has no reset, so a clock edge
        // while reset is held must not modify it.
        wr_aceita    = rst_n & ~ocupado & escrita;
        wr_efetiva   = wr_aceita & wr_no_limite;
        rd_aceita    = ~ocupado & leitura;
        wr_idx       = end_entrada[IDX_W-1:0];
        rd_idx       = end_saida[IDX_W-1:0];
        limpa_idx    = limpa_end[IDX_W-1:0];
    end

    // Array: cleared only by the sweep, never asynchronously.
    always_ff @(posedge clk) begin
        if (limpa_we && rst_n) begin
            mem_q[limpa_idx] <= '0;
        end else if (wr_efetiva) begin
            mem_q[wr_idx] <= entrada;
        end
    end

    // Read data: out-of-range returns zero; a same-cycle write to the same
    // address is forwarded (write-first).
    always_comb begin
        saida_d = mem_q[rd_idx];
        if (!rd_no_limite) begin
            saida_d = '0;
        end else if (wr_efetiva && (end_entrada == end_saida)) begin
            saida_d = entrada;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saida_q  <= '0;
            valida_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            if (rd_aceita) begin
                saida_q <= saida_d;
            end
            valida_q <= rd_aceita;
            erro_q   <= (wr_aceita & ~wr_no_limite) | (rd_aceita & ~rd_no_limite);
        end
    end

    assign saida        = saida_q;
    assign saida_valida = valida_q;
    assign erro_end     = erro_q;

endmodule : mem_ram_dp
`default_nettype wire

// File: tb/tb_mem_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ram_dp
//  Purpose  : Self-checking bench for mem_ram_dp (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ram_dp;

    localparam int PROF = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] entrada = 8'h00;
    logic [6:0] end_entrada = 7'd0;
    logic       escrita = 1'b0;
    logic [6:0] end_saida = 7'd0;
    logic       leitura = 1'b0;
    logic [7:0] saida;
    logic       saida_valida;
    logic       ocupado;
    logic       erro_end;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_ram_dp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entrada      (entrada),
        .end_entrada  (end_entrada),
        .escrita      (escrita),
        .end_saida    (end_saida),
        .leitura      (leitura),
        .saida        (saida),
        .saida_valida (saida_valida),
        .ocupado      (ocupado),
        .erro_end     (erro_end)
    );

    // ------------------------------------------------------------------
    // Reference model: an array of words plus a count of sweep cycles left.
    // ------------------------------------------------------------------
    logic [7:0] m_mem [PROF];
    logic [7:0] m_saida;
    logic       m_valida;
    logic       m_erro;
    int         m_restante;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_saida    <= 8'h00;
            m_valida   <= 1'b0;
            m_erro     <= 1'b0;
            m_restante <= PROF;
            for (int i = 0; i < PROF; i++) m_mem[i] <= 8'h00;
        end else if (m_restante > 0) begin
            m_restante <= m_restante - 1;
            m_valida   <= 1'b0;
            m_erro     <= 1'b0;
        end else begin
            m_valida <= leitura;
            m_erro   <= (escrita && int'(end_entrada) >= PROF) ||
                        (leitura && int'(end_saida) >= PROF);
            if (leitura) begin
                if (int'(end_saida) >= PROF)
                    m_saida <= 8'h00;
                else if (escrita && end_entrada == end_saida)
                    m_saida <= entrada;
                else
                    m_saida <= m_mem[int'(end_saida)];
            end
            if (escrita && int'(end_entrada) < PROF)
                m_mem[int'(end_entrada)] <= entrada;
        end
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("saida",        {24'd0, saida},  {24'd0, m_saida});
            chk("saida_valida", {31'd0, saida_valida}, {31'd0, m_valida});
            chk("erro_end",     {31'd0, erro_end},     {31'd0, m_erro});
            chk("ocupado",      {31'd0, ocupado},      {31'd0, (m_restante > 0)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ociosa();
        escrita = 1'b0;
        leitura = 1'b0;
    endtask

    task automatic espera_varredura(input string nome);
        for (int i = 0; i < 31; i++) tick();
        chk({nome, "_ocupado_c31"}, {31'd0, ocupado}, 32'd1);
        tick();
        chk({nome, "_ocupado_c32"}, {31'd0, ocupado}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_ocupado", {31'd0, ocupado}, 32'd1);
        chk("rst_valida",  {31'd0, saida_valida}, 32'd0);
        chk("rst_saida",   {24'd0, saida}, 32'd0);

        // Sweep after release; port activity must be ignored
        escrita = 1'b1; end_entrada = 7'd3; entrada = 8'h77;
        leitura = 1'b1; end_saida = 7'd3;
        @(negedge clk) rst_n = 1'b1;
        espera_varredura("sweep1");
        ociosa();

        // All words read back as zero, back-to-back
        for (int a = 0; a < PROF; a++) begin
            leitura = 1'b1; end_saida = 7'(a);
            tick();
            chk("clear_valida", {31'd0, saida_valida}, 32'd1);
            chk("clear_saida",  {24'd0, saida}, 32'd0);
        end
        ociosa();
        tick();
        chk("idle_valida", {31'd0, saida_valida}, 32'd0);

        // Write then read
        escrita = 1'b1; end_entrada = 7'd5; entrada = 8'hA5;
        tick();
        escrita = 1'b0; leitura = 1'b1; end_saida = 7'd5;
        tick();
        chk("wr_rd5_saida",  {24'd0, saida}, 32'hA5);
        chk("wr_rd5_valida", {31'd0, saida_valida}, 32'd1);
        ociosa();
        tick();
        chk("hold_saida", {24'd0, saida}, 32'hA5);

        // Write-first collision
        escrita = 1'b1; end_entrada = 7'd9; entrada = 8'h11;
        tick();
        entrada = 8'h3C; leitura = 1'b1; end_saida = 7'd9;
        tick();
        chk("wfirst_saida", {24'd0, saida}, 32'h3C);
        ociosa();

        // Out-of-range write and read
        escrita = 1'b1; end_entrada = 7'd40; entrada = 8'hFF;
        tick();
        chk("oor_wr_erro", {31'd0, erro_end}, 32'd1);
        ociosa();
        tick();
        chk("oor_wr_erro_off", {31'd0, erro_end}, 32'd0);
        leitura = 1'b1; end_saida = 7'd8;
        tick();
        chk("addr8_intact", {24'd0, saida}, 32'h00);
        end_saida = 7'd33;
        tick();
        chk("oor_rd_saida",  {24'd0, saida}, 32'h00);
        chk("oor_rd_valida", {31'd0, saida_valida}, 32'd1);
        chk("oor_rd_erro",   {31'd0, erro_end}, 32'd1);
        ociosa();

        // Back-to-back reads of 0,1,2
        for (int a = 0; a < 3; a++) begin
            escrita = 1'b1; end_entrada = 7'(a); entrada = 8'(8'h50 + a);
            tick();
        end
        ociosa();
        for (int a = 0; a < 3; a++) begin
            leitura = 1'b1; end_saida = 7'(a);
            tick();
            chk("b2b_valida", {31'd0, saida_valida}, 32'd1);
            chk("b2b_saida",  {24'd0, saida}, 32'h50 + 32'(a));
        end
        ociosa();

        // Mixed traffic against the model
        for (int n = 0; n < 300; n++) begin
            escrita     = 1'($urandom_range(0, 1));
            leitura     = 1'($urandom_range(0, 1));
            end_entrada = 7'($urandom_range(0, 40));
            end_saida   = ($urandom_range(0, 3) == 0) ? end_entrada : 7'($urandom_range(0, 40));
            entrada     = 8'($urandom);
            tick();
        end
        ociosa();

        // Reset pulse at sweep cycle 10 restarts the sweep
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        leitura = 1'b1; end_saida = 7'd5;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk) rst_n = 1'b0;
        chk("midrst_ocupado", {31'd0, ocupado}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        espera_varredura("sweep2");
        tick();
        chk("after_sweep_rd5", {24'd0, saida}, 32'h00);
        chk("after_sweep_valida", {31'd0, saida_valida}, 32'd1);
        ociosa();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_ram_dp
`default_nettype wire

// File: doc/mem_ram_dp.md
MEM_RAM_DP -- requirements
Module: mem_ram_dp

Interface
REQ-001 Parameter LARGURA, default 8: data word width in bits.
REQ-002 Parameter PROFUNDIDADE, default 32: number of words, at least 2.
REQ-003 Parameter END_LARG, default 7: address width; SHALL satisfy 2**END_LARG >= PROFUNDIDADE.
REQ-004 Parameter LIMPA_NO_RESET, default 1: 1 = clear whole array after reset, 0 = no clear.
REQ-005 clk  input  1  single clock; all state updates on posedge only.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 entrada  input  LARGURA  write data.
REQ-008 end_entrada  input  END_LARG  write address.
REQ-009 escrita  input  1  write enable.
REQ-010 end_saida  input  END_LARG  read address.
REQ-011 leitura  input  1  read request.
REQ-012 saida  output  LARGURA  registered read data.
REQ-013 saida_valida  output  1  one-cycle pulse: saida updated this cycle.
REQ-014 ocupado  output  1  high while the clear sweep runs; both ports ignored.
REQ-015 erro_end  output  1  one-cycle pulse: out-of-range address on an accepted access.

Function
REQ-016 FSM states: LIMPANDO and PRONTO. Reset enters LIMPANDO if LIMPA_NO_RESET=1, else PRONTO.
REQ-017 LIMPANDO: clear counter starts at 0; writes zero to mem[counter] each cycle; increments.
REQ-018 Exit from LIMPANDO: on the cycle counter = PROFUNDIDADE-1, that word is written and the FSM moves to PRONTO. ocupado is high for exactly PROFUNDIDADE cycles after reset release.
REQ-019 In LIMPANDO, escrita and leitura are ignored: no array write, no saida_valida, no erro_end.
REQ-020 Write accepted in PRONTO when escrita=1 and end_entrada < PROFUNDIDADE; mem[end_entrada] <= entrada at that posedge.
REQ-021 Read accepted in PRONTO when leitura=1 on cycle N. On cycle N+1, saida holds the word and saida_valida=1. Latency is exactly 1; full throughput of one read per cycle.
REQ-022 saida holds its last value when no read is accepted. saida_valida is 0 when no read is accepted.
REQ-023 Read and write to the same in-range address in the same cycle are write-first: saida returns the new entrada.
REQ-024 Out-of-range write (end_entrada >= PROFUNDIDADE) is dropped, and erro_end=1 on the next cycle.
REQ-025 Out-of-range read (end_saida >= PROFUNDIDADE) gives saida=0 and saida_valida=1 on the next cycle, with erro_end=1 on that cycle.
REQ-026 erro_end is the OR of both port errors in the same cycle.
REQ-027 Simultaneous in-range writes and reads to different addresses proceed independently.

Reset
REQ-028 While rst_n=0: saida=0, saida_valida=0, erro_end=0; ocupado=LIMPA_NO_RESET; clear counter=0.
REQ-029 rst_n asserted mid-sweep or mid-operation aborts immediately; the sweep restarts from address 0 after release.
REQ-030 Array contents are not reset asynchronously; they are cleared only by the sweep.

Structure
REQ-031 Package mem_ram_pkg holds the FSM state type (LIMPANDO, PRONTO) and the default parameter constants.
REQ-032 Sub-module mem_ram_limpeza holds the clear counter, the FSM and the ocupado output. The array, ports and error logic stay in mem_ram_dp.

Verification
REQ-033 Reset release with defaults -> ocupado high for 32 cycles; then reads of addresses 0..31 return 0x00, with saida_valida one cycle after each leitura.
REQ-034 Write 0xA5 to address 5, then leitura at address 5 on the next cycle -> saida=0xA5 and saida_valida=1 exactly one cycle later.
REQ-035 Same cycle: escrita and leitura at address 9, entrada=0x3C, old value 0x11 -> saida=0x3C next cycle.
REQ-036 Write to address 40 with entrada=0xFF -> erro_end pulses once and address 8 (40 mod 32) is unchanged. Read of address 33 -> saida=0x00, saida_valida=1, erro_end=1.
REQ-037 rst_n pulsed low at sweep cycle 10 -> ocupado stays high 32 more cycles after release; reads during the sweep give no saida_valida.
REQ-038 Back-to-back reads of addresses 0,1,2 on consecutive cycles -> three consecutive saida_valida pulses with matching data in order.
